// File: rtl/counter_pkg.sv
// counter_pkg: state/command encodings shared between counter_ctrl and the interval counter.
package counter_pkg;
  localparam logic [7:0] STATE_RESET = 8'd0;
  localparam logic [7:0] STATE_RUN = 8'd1;
  localparam logic [7:0] STATE_HALT = 8'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd0;
  localparam logic [1:0] CMD_RUN = 2'd1;
  localparam logic [1:0] CMD_HALT = 2'd2;
  localparam logic [1:0] CMD_LOAD = 2'd3;
  typedef enum logic [1:0] {CLEARING, IDLE, RUNNING, HALTED} fsm_t;
  function automatic logic [7:0] to_state(fsm_t s);
    return s == RUNNING ? STATE_RUN : s == HALTED ? STATE_HALT : STATE_RESET;
  endfunction
endpackage

// File: rtl/ctrl_timer.sv
// ctrl_timer: loadable 32-bit down-counter; done while the count sits at 1.
module ctrl_timer (
  input  logic        clk,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        en,
  output logic        done
);
  logic [31:0] cnt;
  always_ff @(posedge clk)
    if (load) cnt <= load_val;
    else if (en && cnt != 32'd0) cnt <= cnt - 32'd1;
  assign done = cnt == 32'd1;
endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: host command sequencer driving the interval counter's state/inter inputs.
// Optional run-length auto-halt enabled by defining COUNTER_CTRL_AUTO_HALT_EN.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int          CLEAR_CYCLES  = 4,
  parameter logic [31:0] INTER_DEFAULT = 32'd100,
  parameter logic [31:0] RUN_LIMIT     = 32'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic [7:0]  state,
  output logic [31:0] inter,
  output logic        cmd_err,
  output logic        auto_halt
);
  fsm_t fsm, fsm_n;
  logic [31:0] inter_n;
  logic err_n, ah_n, accept, clear_acc, clr_done;
  assign cmd_ready = fsm != CLEARING;
  assign accept = cmd_valid && cmd_ready;
  assign clear_acc = accept && cmd_op == CMD_CLEAR;
  ctrl_timer u_clr (
    .clk(clk), .load(rst || clear_acc), .load_val(32'(CLEAR_CYCLES)),
    .en(fsm == CLEARING), .done(clr_done)
  );
`ifdef COUNTER_CTRL_AUTO_HALT_EN
  logic run_done;
  // Counting down from RUN_LIMIT reaches 1 in the same cycle an up-count from 0 reaches RUN_LIMIT-1.
  ctrl_timer u_run (
    .clk(clk), .load(fsm_n == RUNNING && fsm != RUNNING), .load_val(RUN_LIMIT),
    .en(fsm == RUNNING), .done(run_done)
  );
`else
  logic unused_limit;
  assign unused_limit = ^RUN_LIMIT;
`endif
  always_comb begin
    fsm_n = fsm;
    inter_n = inter;
    err_n = 1'b0;
    ah_n = 1'b0;
    if (fsm == CLEARING && clr_done) fsm_n = IDLE;
    if (accept)
      case (cmd_op)
        CMD_CLEAR: fsm_n = CLEARING;
        CMD_RUN:   fsm_n = RUNNING;
        CMD_HALT:  if (fsm == IDLE) err_n = 1'b1; else fsm_n = HALTED;
        default:   if (fsm == RUNNING) err_n = 1'b1; else inter_n = cmd_data;
      endcase
`ifdef COUNTER_CTRL_AUTO_HALT_EN
    if (fsm == RUNNING && run_done && !clear_acc) begin
      fsm_n = HALTED;
      ah_n = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk)
    if (rst) begin
      fsm <= CLEARING;
      state <= STATE_RESET;
      inter <= INTER_DEFAULT;
      cmd_err <= 1'b0;
      auto_halt <= 1'b0;
    end else begin
      fsm <= fsm_n;
      state <= to_state(fsm_n);
      inter <= inter_n;
      cmd_err <= err_n;
      auto_halt <= ah_n;
    end
endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed plus random stimulus checked against a behavioural model of the command rules.
module tb_counter_ctrl;
  localparam int CLR = 4;
  localparam int LIM = 5;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_ready, cmd_err, auto_halt;
  logic [1:0] cmd_op = 2'd0;
  logic [31:0] cmd_data = 32'd0, inter;
  logic [7:0] state;
  int errors = 0, checks = 0;
  int m_mode = 0, m_clr = CLR, m_run = 0;
  logic [31:0] m_inter = 32'd100;
  logic m_err = 1'b0, m_ah = 1'b0;

  counter_ctrl #(.CLEAR_CYCLES(CLR), .INTER_DEFAULT(32'd100), .RUN_LIMIT(32'(LIM))) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .state(state), .inter(inter), .cmd_err(cmd_err), .auto_halt(auto_halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode: 0 reset/idle, 1 running, 2 halted; m_clr counts remaining busy cycles
  task automatic model_edge();
    int old = m_mode;
    bit acc = cmd_valid && m_clr == 0;
    bit clr = acc && cmd_op == 2'd0;
    m_err = 1'b0;
    m_ah = 1'b0;
    if (rst) begin
      m_mode = 0; m_clr = CLR; m_inter = 32'd100; m_run = 0;
      return;
    end
    if (m_clr > 0) m_clr--;
    if (old == 1) m_run++;
    if (acc)
      case (cmd_op)
        2'd0: begin m_mode = 0; m_clr = CLR; end
        2'd1: if (old != 1) begin m_mode = 1; m_run = 0; end
        2'd2: if (old == 0) m_err = 1'b1; else m_mode = 2;
        default: if (old == 1) m_err = 1'b1; else m_inter = cmd_data;
      endcase
`ifdef COUNTER_CTRL_AUTO_HALT_EN
    if (old == 1 && m_run == LIM && !clr) begin m_mode = 2; m_ah = 1'b1; end
`endif
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] op, input logic [31:0] d);
    rst = r; cmd_valid = v; cmd_op = op; cmd_data = d;
    @(posedge clk);
    model_edge();
    #1;
    check("state", 32'(state), 32'(m_mode));
    check("inter", inter, m_inter);
    check("cmd_err", 32'(cmd_err), 32'(m_err));
    check("auto_halt", 32'(auto_halt), 32'(m_ah));
    check("cmd_ready", 32'(cmd_ready), 32'(m_clr == 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  initial begin
    step(1'b1, 1'b0, 2'd0, 32'd0);
    step(1'b1, 1'b0, 2'd0, 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_inter", inter, 32'd100);
    idle(CLR + 1);
    check("ready_after_clear", 32'(cmd_ready), 32'd1);
    step(1'b0, 1'b1, 2'd3, 32'd7);
    check("load7", inter, 32'd7);
    step(1'b0, 1'b1, 2'd1, 32'd0);
    check("run", 32'(state), 32'd1);
    step(1'b0, 1'b1, 2'd3, 32'd9);
    check("load_in_run_err", 32'(cmd_err), 32'd1);
    step(1'b0, 1'b1, 2'd2, 32'd0);
    check("halt", 32'(state), 32'd2);
    step(1'b0, 1'b1, 2'd1, 32'd0);
    step(1'b0, 1'b1, 2'd0, 32'd0);
    check("clear_keeps_inter", inter, 32'd7);
    idle(CLR + 1);
    step(1'b0, 1'b1, 2'd2, 32'd0);
    step(1'b0, 1'b1, 2'd2, 32'd0);
    check("halt_idle_err2", 32'(cmd_err), 32'd1);
    step(1'b0, 1'b1, 2'd3, 32'd0);
    check("load_zero", inter, 32'd0);
    step(1'b0, 1'b1, 2'd0, 32'd0);
    for (int i = 0; i < CLR + 2; i++) step(1'b0, 1'b1, 2'd1, 32'd0);
    check("held_run", 32'(state), 32'd1);
    idle(LIM + 3);
`ifdef COUNTER_CTRL_AUTO_HALT_EN
    check("auto_halted", 32'(state), 32'd2);
    step(1'b0, 1'b1, 2'd1, 32'd0);
    idle(LIM - 1);
    step(1'b0, 1'b1, 2'd0, 32'd0);
    check("clear_beats_auto", 32'(state), 32'd0);
    idle(CLR + 1);
    step(1'b0, 1'b1, 2'd1, 32'd0);
    idle(LIM - 1);
    step(1'b0, 1'b1, 2'd3, 32'd5);
    check("load_at_limit_err", 32'(cmd_err), 32'd1);
`endif
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)),
           $urandom_range(0, 3) == 0 ? 32'd0 : $urandom);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
